// File: rtl/axi_aw_wr_sequencer_if.sv
// Bundle of AW request, master AW, ID-FIFO push and write-completion signals
// around the write-address sequencer. The master modport is the sequencer's
// view. The slave modport is the view of the surrounding node, or of a bench.
interface axi_aw_wr_sequencer_if #(
  parameter int N_TARG_PORT     = 7,
  parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
  parameter int AW_PAYLOAD_W    = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) ();
  logic [N_TARG_PORT-1:0]                      awvalid_i;
  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0]    awpayload_i;
  logic [N_TARG_PORT-1:0]                      awready_o;
  logic                                        awvalid_o;
  logic [AW_PAYLOAD_W-1:0]                     awpayload_o;
  logic                                        awready_i;
  logic                                        push_ID_o;
  logic [LOG_N_TARG+N_TARG_PORT-1:0]           ID_o;
  logic                                        grant_FIFO_ID_i;
  logic                                        bdone_i;
  logic [CNT_W-1:0]                            outstanding_o;

  modport master (
    input  awvalid_i, awpayload_i, awready_i, grant_FIFO_ID_i, bdone_i,
    output awready_o, awvalid_o, awpayload_o, push_ID_o, ID_o, outstanding_o
  );

  modport slave (
    output awvalid_i, awpayload_i, awready_i, grant_FIFO_ID_i, bdone_i,
    input  awready_o, awvalid_o, awpayload_o, push_ID_o, ID_o, outstanding_o
  );
endinterface

// File: rtl/axi_aw_wr_sequencer.sv
// Write-address sequencer for one master port of the AXI node.
// This block arbitrates the slave-port AW requests in round-robin order. It
// registers the winner onto the master AW channel. In the same cycle it pushes
// {binary id, one-hot id} into the write-data ID FIFO, so W beats follow the
// AW issue order.
// Optional feature macro: AXI_AW_OUTSTANDING_LIMIT_EN. When it is defined, AW
// issue is throttled against completed B responses. When it is undefined, the
// counter is removed, outstanding is tied to 0 and bdone is ignored.
module axi_aw_wr_sequencer #(
  parameter int N_TARG_PORT     = 7,
  parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
  parameter int AW_PAYLOAD_W    = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_aw_wr_sequencer_if.master bus
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam int LAST_INT = N_TARG_PORT - 1;
  localparam logic [LOG_N_TARG:0]   N_EXT     = N_TARG_PORT[LOG_N_TARG:0];
  localparam logic [LOG_N_TARG-1:0] LAST_PORT = LAST_INT[LOG_N_TARG-1:0];
  localparam logic [LOG_N_TARG-1:0] PTR_ONE   = {{(LOG_N_TARG-1){1'b0}}, 1'b1};

  state_t                    state_r;
  logic [LOG_N_TARG-1:0]     rr_ptr_r;
  logic [AW_PAYLOAD_W-1:0]   payload_r;

  logic                      found_s;
  logic [LOG_N_TARG-1:0]     winner_s;
  logic [LOG_N_TARG:0]       idx_s;
  logic [N_TARG_PORT-1:0]    onehot_s;
  logic [LOG_N_TARG-1:0]     rr_next_s;
  logic                      slot_free_s;
  logic                      limit_ok_s;
  logic                      accept_s;

  // Round-robin search: first requesting port at or after rr_ptr, with wrap-around
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = '0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      idx_s = {1'b0, rr_ptr_r} + i[LOG_N_TARG:0];
      if (idx_s >= N_EXT) begin
        idx_s = idx_s - N_EXT;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && bus.awvalid_i[idx_s[LOG_N_TARG-1:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_s[LOG_N_TARG-1:0];
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // A FULL register can be refilled in the same cycle that the master takes it
  assign slot_free_s = (state_r == EMPTY) || bus.awready_i;
  assign accept_s    = slot_free_s && found_s && bus.grant_FIFO_ID_i && limit_ok_s;
  assign rr_next_s   = (winner_s == LAST_PORT) ? '0 : winner_s + PTR_ONE;

  // One-hot accept vector; it stays zero when there is no accept
  always_comb begin
    onehot_s = '0;
    if (accept_s) begin
      onehot_s[winner_s] = 1'b1;
    end else begin
      onehot_s = '0;
    end
  end

  assign bus.awready_o   = onehot_s;
  assign bus.push_ID_o   = accept_s;
  assign bus.ID_o        = accept_s ? {winner_s, onehot_s} : '0;
  assign bus.awvalid_o   = (state_r == FULL);
  assign bus.awpayload_o = payload_r;

  // Output-register FSM: capture the winner and advance the pointer on accept; drain when the master takes the AW
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= EMPTY;
      rr_ptr_r  <= '0;
      payload_r <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r   <= FULL;
            payload_r <= bus.awpayload_i[winner_s];
            rr_ptr_r  <= rr_next_s;
          end else begin
            state_r   <= EMPTY;
          end
        end
        FULL: begin
          if (accept_s) begin
            state_r   <= FULL;
            payload_r <= bus.awpayload_i[winner_s];
            rr_ptr_r  <= rr_next_s;
          end else if (bus.awready_i) begin
            state_r   <= EMPTY;
          end else begin
            state_r   <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

`ifdef AXI_AW_OUTSTANDING_LIMIT_EN
  localparam logic [CNT_W-1:0] MAX_CNT = MAX_OUTSTANDING[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;
  logic             dec_s;

  // At the limit, a completion in the same cycle frees a slot for a new accept
  assign limit_ok_s = (count_r < MAX_CNT) || ((count_r == MAX_CNT) && bus.bdone_i);
  assign dec_s      = bus.bdone_i && (count_r != '0);

  // Outstanding counter: +1 per accept, -1 per completion, saturating at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      case ({accept_s, dec_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.outstanding_o = count_r;
`else
  logic unused_bdone;

  assign limit_ok_s        = 1'b1;
  assign bus.outstanding_o = '0;
  assign unused_bdone      = bus.bdone_i;
`endif

endmodule

// File: tb/tb_axi_aw_wr_sequencer.sv
// Directed bench for axi_aw_wr_sequencer. The stimulus pushes the expected
// accepts and AW issues into queues. A monitor at the falling edge pops these
// entries and compares them with the DUT outputs.
module tb_axi_aw_wr_sequencer;
  localparam int N    = 7;
  localparam int LOGN = $clog2(N);
  localparam int W    = 64;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int           exp_acc_q[$];
  logic [W-1:0] exp_aw_q[$];
  logic [W-1:0] pl [N];

  always #5 clk = ~clk;

  axi_aw_wr_sequencer_if #(.N_TARG_PORT(N), .AW_PAYLOAD_W(W), .MAX_OUTSTANDING(MAXO)) bus ();

  axi_aw_wr_sequencer #(.N_TARG_PORT(N), .AW_PAYLOAD_W(W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic ar, input logic g, input logic bd);
    @(posedge clk);
    #1;
    bus.awvalid_i       = v;
    bus.awready_i       = ar;
    bus.grant_FIFO_ID_i = g;
    bus.bdone_i         = bd;
  endtask

  task automatic expect_acc(input int p);
    exp_acc_q.push_back(p);
    exp_aw_q.push_back(pl[p]);
  endtask

  // Monitor: compare accepts and issued AWs against the scoreboard queues
  initial begin
    int                   p;
    logic [N-1:0]         exp_rdy;
    logic [LOGN-1:0]      pb;
    logic [LOGN+N-1:0]    exp_id;
    logic [W-1:0]         exp_pl;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.push_ID_o || (bus.awready_o != '0)) begin
          checks++;
          if (exp_acc_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_accept: awready_o=%0h push_ID_o=%0b, no accept expected",
                     bus.awready_o, bus.push_ID_o);
          end else begin
            p       = exp_acc_q.pop_front();
            exp_rdy = '0;
            exp_rdy[p] = 1'b1;
            pb      = p[LOGN-1:0];
            exp_id  = {pb, exp_rdy};
            if (bus.awready_o !== exp_rdy || bus.push_ID_o !== 1'b1 || bus.ID_o !== exp_id) begin
              errors++;
              $display("FAIL accept_port%0d: awready_o=%0h push=%0b ID_o=%0h expected awready_o=%0h push=1 ID_o=%0h",
                       p, bus.awready_o, bus.push_ID_o, bus.ID_o, exp_rdy, exp_id);
            end
          end
        end else begin
          chk("idle_ID_o", W'(bus.ID_o), '0);
        end
        checks++;
        if (exp_acc_q.size() != 0) begin
          errors++;
          $display("FAIL missed_accept: got no accept, expected port %0d", exp_acc_q[0]);
          exp_acc_q.delete();
        end
        if (bus.awvalid_o && bus.awready_i) begin
          checks++;
          if (exp_aw_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_aw: got payload %0h, expected no AW", bus.awpayload_o);
          end else begin
            exp_pl = exp_aw_q.pop_front();
            if (bus.awpayload_o !== exp_pl) begin
              errors++;
              $display("FAIL aw_payload: got %0h expected %0h", bus.awpayload_o, exp_pl);
            end
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    for (int p = 0; p < N; p++) begin
      pl[p] = {32'hCAFE_0000, 32'(p)};
    end
    pl[3] = 64'h0000_0000_0000_00A5;
    for (int p = 0; p < N; p++) begin
      bus.awpayload_i[p] = pl[p];
    end
    bus.awvalid_i       = '0;
    bus.awready_i       = 1'b0;
    bus.grant_FIFO_ID_i = 1'b0;
    bus.bdone_i         = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid_o",     W'(bus.awvalid_o), '0);
    chk("rst_awpayload_o",   bus.awpayload_o, '0);
    chk("rst_awready_o",     W'(bus.awready_o), '0);
    chk("rst_push_ID_o",     W'(bus.push_ID_o), '0);
    chk("rst_ID_o",          W'(bus.ID_o), '0);
    chk("rst_outstanding_o", W'(bus.outstanding_o), '0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_awvalid_o", W'(bus.awvalid_o), '0);

    // Single request from port 3, then check the issued AW
    step(7'h08, 1'b1, 1'b1, 1'b1);
    expect_acc(3);
    @(negedge clk);
    chk("p3_awready_o", W'(bus.awready_o), 64'h08);
    step(7'h00, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("p3_awvalid_o", W'(bus.awvalid_o), 64'h1);
    chk("p3_awpayload_o", bus.awpayload_o, 64'hA5);

    // rr_ptr is now 4: ports 2 and 5 request, so port 5 must win
    step(7'b010_0100, 1'b1, 1'b1, 1'b1);
    expect_acc(5);
    @(negedge clk);
    step(7'h40, 1'b1, 1'b1, 1'b1);
    expect_acc(6);
    @(negedge clk);

    // All ports request back to back, starting from rr_ptr 0
    for (int k = 0; k < 8; k++) begin
      step(7'h7F, 1'b1, 1'b1, 1'b1);
      expect_acc(k % N);
      @(negedge clk);
    end

    // The master stalls for 5 cycles while the register holds port 0's AW
    for (int k = 0; k < 5; k++) begin
      step(7'h7F, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("stall_awvalid_o",   W'(bus.awvalid_o), 64'h1);
      chk("stall_awpayload_o", bus.awpayload_o, pl[0]);
      chk("stall_awready_o",   W'(bus.awready_o), '0);
    end
    step(7'h7F, 1'b1, 1'b1, 1'b1);
    expect_acc(1);
    @(negedge clk);
    step(7'h00, 1'b1, 1'b1, 1'b1);
    @(negedge clk);

    // No FIFO grant while port 1 requests, then the grant returns
    for (int k = 0; k < 4; k++) begin
      step(7'h02, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("nogrant_push_ID_o", W'(bus.push_ID_o), '0);
    end
    step(7'h02, 1'b1, 1'b1, 1'b1);
    expect_acc(1);
    @(negedge clk);
    step(7'h00, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    step(7'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

`ifdef AXI_AW_OUTSTANDING_LIMIT_EN
    chk("lim_zero", W'(bus.outstanding_o), '0);
    step(7'h00, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    step(7'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lim_bdone_at_zero", W'(bus.outstanding_o), '0);
    // rr_ptr is 2: port 3 is granted twice, then the limit of 2 is reached
    step(7'h08, 1'b1, 1'b1, 1'b0);
    expect_acc(3);
    @(negedge clk);
    step(7'h08, 1'b1, 1'b1, 1'b0);
    expect_acc(3);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      step(7'h08, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("lim_stall_count", W'(bus.outstanding_o), 64'h2);
    end
    step(7'h08, 1'b1, 1'b1, 1'b1);
    expect_acc(3);
    @(negedge clk);
    step(7'h08, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lim_bdone_accept_count", W'(bus.outstanding_o), 64'h2);
    step(7'h00, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    step(7'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lim_after_one_bdone", W'(bus.outstanding_o), 64'h1);
`else
    // Without the limiter, 20 back-to-back accepts with no bdone all pass
    for (int k = 0; k < 20; k++) begin
      step(7'h10, 1'b1, 1'b1, 1'b0);
      expect_acc(4);
      @(negedge clk);
      chk("nolim_outstanding_o", W'(bus.outstanding_o), '0);
    end
    step(7'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
`endif

    step(7'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("aw_queue_drained", W'(exp_aw_q.size()), '0);
    chk("final_awvalid_o", W'(bus.awvalid_o), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_aw_wr_sequencer.md
# axi_aw_wr_sequencer

Write-address sequencer for one master port of the AXI node. It round-robin arbitrates AW requests from N_TARG_PORT slave ports, registers the winner onto the master AW channel, and pushes the winner's {BIN_ID, OH_ID} into the write-data allocator's ID FIFO in the same cycle. W beats are therefore routed strictly in AW issue order. An optional outstanding-write limiter throttles AW issue against completed B responses.

## Interface
Parameters:
- N_TARG_PORT, 7, number of slave-side requesters
- LOG_N_TARG, $clog2(N_TARG_PORT), binary ID width
- AW_PAYLOAD_W, 64, packed AW payload width (addr, len, size, burst, id, user…)
- MAX_OUTSTANDING, 8, maximum issued-but-unanswered writes (limiter only)
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- awvalid_i  in  N_TARG_PORT  per-port AW request
- awpayload_i  in  N_TARG_PORT×AW_PAYLOAD_W  per-port AW payload
- awready_o  out  N_TARG_PORT  per-port accept, one-hot or zero
- awvalid_o  out  1  master AW valid (registered)
- awpayload_o  out  AW_PAYLOAD_W  master AW payload (registered)
- awready_i  in  1  master AW ready
- push_ID_o  out  1  push into write-data allocator ID FIFO
- ID_o  out  LOG_N_TARG+N_TARG_PORT  {BIN_ID, OH_ID} of the accepted port
- grant_FIFO_ID_i  in  1  ID FIFO can accept a push
- bdone_i  in  1  one write response completed (B handshake on master side)
- outstanding_o  out  CNT_W  current outstanding count (0 when limiter compiled out)

## Operation
- State: 2-state FSM, EMPTY (output register free) and FULL (awvalid_o=1, holding payload). Plus rr_ptr (LOG_N_TARG) and outstanding counter.
- The slot is free when the state is EMPTY, or when the state is FULL and awready_i=1 (pass-through refill).
- Accept condition: the slot is free, at least one awvalid_i bit is set, grant_FIFO_ID_i=1, and (limiter) the count is below MAX_OUTSTANDING, or the count equals MAX_OUTSTANDING with bdone_i=1 in the same cycle.
- Winner: the first set awvalid_i bit searching from index rr_ptr upward, wrapping N_TARG_PORT-1 → 0.
- On accept, in the same cycle:
  - awready_o[winner]=1;
  - push_ID_o=1 and ID_o={winner binary, one-hot winner};
  - the payload is captured into the output register;
  - the state becomes FULL;
  - rr_ptr becomes winner+1, wrapping to 0 after N_TARG_PORT-1.
- With no accept while FULL and awready_i=1, the state becomes EMPTY.
- push_ID_o is never asserted without an accept. Without an accept, awready_o=0, push_ID_o=0 and ID_o=0.
- Counter:
  - +1 on accept, −1 on bdone_i; both in the same cycle leave it unchanged.
  - bdone_i at count 0 is ignored: the counter saturates at 0.
  - The counter never exceeds MAX_OUTSTANDING.
- awvalid_o is held and awpayload_o is stable while awready_i=0 (AXI rule). Requesters may drop awvalid_i before being accepted; only the current-cycle request vector is used.

## Timing
- Reset values: awvalid_o=0, awpayload_o=0, awready_o=0, push_ID_o=0, ID_o=0, outstanding_o=0, state EMPTY, rr_ptr=0.
- Reset asserted mid-operation drops awvalid_o at the next edge. The in-flight AW and its FIFO entry are the system reset's responsibility.
- Latency: accepted in cycle N → awvalid_o=1 with that payload in cycle N+1.
- Throughput: one AW per cycle while awready_i=1 and grant_FIFO_ID_i=1.
- grant_FIFO_ID_i=0 blocks accepts. The register content already issued is unaffected.
- awready_o, push_ID_o and ID_o are combinational from awvalid_i, awready_i, grant_FIFO_ID_i, bdone_i and registered state. No combinational path runs from awvalid_i to awvalid_o.

## Configuration
- AXI_AW_OUTSTANDING_LIMIT_EN defined: the counter and limit are active as described above.
- Not defined: the counter logic is removed, outstanding_o is tied to 0, and bdone_i is ignored. Accept depends only on the free slot, a request, and grant_FIFO_ID_i.

## Test plan
- Reset, then idle: all outputs 0. Port 3 requests with payload 0xA5 → awready_o=0x08, push_ID_o=1, ID_o={3,7'b0001000} in the same cycle; next cycle awvalid_o=1, awpayload_o=0xA5; rr_ptr=4.
- All 7 ports request continuously, awready_i=1, FIFO granting: grant order 0,1,2,3,4,5,6,0, one per cycle, with each ID_o matching its awready_o.
- awready_i=0 for 5 cycles while FULL: awvalid_o and awpayload_o stay stable, awready_o=0, no push. On awready_i=1, a new accept happens in the same cycle.
- grant_FIFO_ID_i=0 with port 1 requesting for 4 cycles: no accept, no push. grant returns → accept in that cycle.
- Limiter on, MAX_OUTSTANDING=2: after 2 accepts with no bdone_i, requests stall and outstanding_o=2. A bdone_i pulse alongside a pending request → accept in the same cycle and the count stays 2. bdone_i at count 0 → count stays 0.
- Limiter compiled out: 20 back-to-back accepts with no bdone_i all pass and outstanding_o=0.
